pipe_perf_monitor: RTL and testbench

//  Synthesizable, parametrised successor to the bench-side stall/flush counting around the pipelined CPU.

---
 rtl/pipe_perf_pkg.sv | 18 +
 rtl/pipe_perf_monitor_sat_counter.sv | 38 +++
 rtl/pipe_perf_monitor.sv | 148 ++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_perf_pkg.sv
// Shared types and index constants for the pipeline performance monitor.
package pipe_perf_pkg;

    // Monitor run state
    typedef enum logic [1:0] {
        PM_IDLE   = 2'd0,
        PM_RUN    = 2'd1,
        PM_HALTED = 2'd2
    } pm_state_e;

    // Counter index 0 is always the cycle counter; events follow at evt_i bit + 1
    localparam int PM_IDX_CYCLE  = 0;
    localparam int PM_EVT_STALL  = 1;
    localparam int PM_EVT_FLUSH  = 2;
    localparam int PM_EVT_RETIRE = 3;
    localparam int PM_EVT_LDUSE  = 4;

endpackage

// File: rtl/pipe_perf_monitor_sat_counter.sv
// Saturating up-counter with a sticky overflow flag and synchronous clear.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    // Count up on inc_i; at all-ones hold the value and latch the overflow flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (inc_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Cycle/event performance monitor: live saturating counters, cycle-limit halt,
// a shadow bank captured on snap_i and a registered shadow readout port.
module pipe_perf_monitor
    import pipe_perf_pkg::*;
#(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clr_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               running_o,
    output logic               halt_o,
    output logic [NUM_EVT:0]   ovf_o
);

    localparam int NUM_CNT = NUM_EVT + 1;

    pm_state_e          state_q;
    logic               running_q;
    logic               halt_q;
    logic               run_s;
    logic               limit_hit_s;
    logic [CNT_W:0]     cyc_nxt_s;
    logic [NUM_CNT-1:0] inc_s;
    logic [NUM_CNT-1:0] ovf_s;
    logic [CNT_W-1:0]   live_s   [NUM_CNT];
    logic [CNT_W-1:0]   shadow_q [NUM_CNT];
    logic [CNT_W-1:0]   rd_data_d;
    logic [CNT_W-1:0]   rd_data_q;

    assign run_s = (state_q == PM_RUN);

    // Increment enables: cycle counter every RUN clock, events when their strobe is high
    always_comb begin
        inc_s = '0;
        inc_s[PM_IDX_CYCLE] = run_s;
        for (int k = 1; k < NUM_CNT; k++) begin
            inc_s[k] = run_s & evt_i[k-1];
        end
    end

    // Limit detect one bit wider so a saturated cycle counter never wraps onto the limit
    always_comb begin
        cyc_nxt_s = {1'b0, live_s[PM_IDX_CYCLE]} + {{CNT_W{1'b0}}, 1'b1};
        if (run_s && (limit_i != '0) && (cyc_nxt_s == {1'b0, limit_i})) begin
            limit_hit_s = 1'b1;
        end else begin
            limit_hit_s = 1'b0;
        end
    end

    // Live counters; clear dominates, counting happens only in RUN
    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_i),
            .inc_i (inc_s[k]),
            .cnt_o (live_s[k]),
            .ovf_o (ovf_s[k])
        );
    end

    // Run-state FSM with registered status outputs; clear beats start
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= PM_IDLE;
            running_q <= 1'b0;
            halt_q    <= 1'b0;
        end else if (clr_i) begin
            state_q   <= PM_IDLE;
            running_q <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            case (state_q)
                PM_IDLE: begin
                    if (start_i) begin
                        state_q   <= PM_RUN;
                        running_q <= 1'b1;
                    end
                end
                PM_RUN: begin
                    if (limit_hit_s) begin
                        state_q   <= PM_HALTED;
                        running_q <= 1'b0;
                        halt_q    <= 1'b1;
                    end
                end
                PM_HALTED: begin
                    state_q <= PM_HALTED;
                end
                default: begin
                    state_q   <= PM_IDLE;
                    running_q <= 1'b0;
                    halt_q    <= 1'b0;
                end
            endcase
        end
    end

    // Readout mux: selects beyond the last counter return zero
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            rd_data_d = (rd_sel_i == SEL_W'(k)) ? shadow_q[k] : rd_data_d;
        end
    end

    // Shadow bank captures pre-increment live values; readout is registered
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                shadow_q[k] <= '0;
            end
            rd_data_q <= '0;
        end else if (clr_i) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                shadow_q[k] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (snap_i) begin
                for (int k = 0; k < NUM_CNT; k++) begin
                    shadow_q[k] <= live_s[k];
                end
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign cycle_o   = live_s[PM_IDX_CYCLE];
    assign running_o = running_q;
    assign halt_o    = halt_q;
    assign ovf_o     = ovf_s;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor: a default-width instance for
// limit/snapshot/readout behaviour and a 4-bit instance for saturation.
module tb_pipe_perf_monitor;

    logic        clk;
    logic        rst_n;

    logic        start, clr, snap;
    logic [3:0]  evt;
    logic [31:0] limit;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data, cycle;
    logic        running, halt;
    logic [4:0]  ovf;

    logic        start4, clr4, snap4;
    logic [3:0]  evt4;
    logic [3:0]  limit4;
    logic [2:0]  rd_sel4;
    logic [3:0]  rd_data4, cycle4;
    logic        running4, halt4;
    logic [4:0]  ovf4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q [$];

    pipe_perf_monitor dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr),
        .evt_i(evt), .limit_i(limit), .snap_i(snap), .rd_sel_i(rd_sel),
        .rd_data_o(rd_data), .cycle_o(cycle), .running_o(running),
        .halt_o(halt), .ovf_o(ovf)
    );

    pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start4), .clr_i(clr4),
        .evt_i(evt4), .limit_i(limit4), .snap_i(snap4), .rd_sel_i(rd_sel4),
        .rd_data_o(rd_data4), .cycle_o(cycle4), .running_o(running4),
        .halt_o(halt4), .ovf_o(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a shadow index, queue its expected value, compare one cycle later
    task automatic rd_check(input string tag, input logic [2:0] sel, input logic [63:0] exp);
        rd_sel = sel;
        exp_q.push_back(exp);
        step();
        check_val(tag, 64'(rd_data), exp_q.pop_front());
    endtask

    task automatic clear_main();
        clr = 1'b1; start = 1'b0; evt = 4'd0; snap = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic run_until_halt(input int budget);
        for (int i = 0; i < budget && !halt; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; clr = 1'b0; snap = 1'b0; evt = 4'd0; limit = 32'd0; rd_sel = 3'd0;
        start4 = 1'b0; clr4 = 1'b0; snap4 = 1'b0; evt4 = 4'd0; limit4 = 4'd0; rd_sel4 = 3'd0;
        #12;
        check_val("rst_cycle",   64'(cycle),   64'd0);
        check_val("rst_rd_data", 64'(rd_data), 64'd0);
        check_val("rst_running", 64'(running), 64'd0);
        check_val("rst_halt",    64'(halt),    64'd0);
        check_val("rst_ovf",     64'(ovf),     64'd0);
        rst_n = 1'b1;
        step();

        // Test 1: limit 10, event 0 every cycle
        limit = 32'd10; evt = 4'b0001; start = 1'b1;
        step();
        check_val("t1_running", 64'(running), 64'd1);
        run_until_halt(40);
        check_val("t1_halt",    64'(halt),    64'd1);
        check_val("t1_cycle",   64'(cycle),   64'd10);
        check_val("t1_running_off", 64'(running), 64'd0);
        step();
        check_val("t1_cycle_frozen", 64'(cycle), 64'd10);
        check_val("t1_halt_hold_start", 64'(halt), 64'd1);
        snap = 1'b1; step(); snap = 1'b0;
        rd_check("t1_evt0", 3'd1, 64'd10);
        rd_check("t1_cyc",  3'd0, 64'd10);

        // Test 2: pattern 0101 for 6 RUN cycles, then snapshot and readout
        limit = 32'd0;
        clear_main();
        check_val("t2_clr_cycle", 64'(cycle), 64'd0);
        check_val("t2_clr_halt",  64'(halt),  64'd0);
        start = 1'b1;
        step();
        evt = 4'b0101;
        for (int i = 0; i < 6; i++) step();
        evt = 4'b0000; snap = 1'b1;
        step();
        snap = 1'b0;
        rd_check("t2_sel1", 3'd1, 64'd6);
        rd_check("t2_sel2", 3'd2, 64'd0);
        rd_check("t2_sel3", 3'd3, 64'd6);
        rd_check("t2_sel4", 3'd4, 64'd0);
        rd_check("t2_sel0", 3'd0, 64'd6);
        rd_check("t2_sel5", 3'd5, 64'd0);
        rd_check("t2_sel7", 3'd7, 64'd0);

        // Test 3: snap and event in the same cycle
        clear_main();
        start = 1'b1;
        step();
        evt = 4'b0010;
        for (int i = 0; i < 7; i++) step();
        snap = 1'b1;
        step();
        snap = 1'b0; evt = 4'b0000;
        rd_check("t3_shadow_pre", 3'd2, 64'd7);
        snap = 1'b1; step(); snap = 1'b0;
        rd_check("t3_live_post", 3'd2, 64'd8);

        // Test 4: 4-bit counters, unlimited, saturation and clear
        start4 = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        check_val("t4_cycle_sat", 64'(cycle4), 64'd15);
        check_val("t4_ovf",       64'(ovf4),   64'b00001);
        limit4 = 4'd3;
        step(); step();
        check_val("t4_no_halt_low_limit", 64'(halt4), 64'd0);
        check_val("t4_ovf_held",  64'(ovf4),   64'b00001);
        check_val("t4_cycle_held", 64'(cycle4), 64'd15);
        clr4 = 1'b1;
        step();
        clr4 = 1'b0; start4 = 1'b0;
        check_val("t4_clr_cycle",   64'(cycle4),   64'd0);
        check_val("t4_clr_ovf",     64'(ovf4),     64'd0);
        check_val("t4_clr_running", 64'(running4), 64'd0);
        step();
        check_val("t4_idle_cycle", 64'(cycle4), 64'd0);

        // Test 5: asynchronous reset mid-run
        clear_main();
        start = 1'b1; evt = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) step();
        snap = 1'b1; step(); snap = 1'b0;
        rd_sel = 3'd0; step();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_cycle",   64'(cycle),   64'd0);
        check_val("t5_rst_running", 64'(running), 64'd0);
        check_val("t5_rst_rd_data", 64'(rd_data), 64'd0);
        check_val("t5_rst_ovf",     64'(ovf),     64'd0);
        #1;
        rst_n = 1'b1; start = 1'b0;
        step(); step();
        check_val("t5_idle_running", 64'(running), 64'd0);
        check_val("t5_idle_cycle",   64'(cycle),   64'd0);
        rd_check("t5_no_snapshot", 3'd0, 64'd0);
        start = 1'b1;
        step();
        check_val("t5_start", 64'(running), 64'd1);

        // Test 6: clear and start together while halted
        clear_main();
        evt = 4'd0; limit = 32'd3; start = 1'b1;
        step();
        run_until_halt(20);
        check_val("t6_halt",  64'(halt),  64'd1);
        check_val("t6_cycle", 64'(cycle), 64'd3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_val("t6_idle_running", 64'(running), 64'd0);
        check_val("t6_idle_halt",    64'(halt),    64'd0);
        check_val("t6_idle_cycle",   64'(cycle),   64'd0);
        step();
        check_val("t6_run_again", 64'(running), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
